// File: rtl/pll_lock_seq_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// The master side drives extlock/stdby_req; the slave (sequencer) drives everything else.
interface pll_lock_seq_if;
    logic       extlock;
    logic       stdby_req;
    logic       pll_reset;
    logic       pll_stdby;
    logic       locked;
    logic       sys_rst_n;
    logic       stdby_ack;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lol_cnt;

    modport master (
        output extlock, stdby_req,
        input  pll_reset, pll_stdby, locked, sys_rst_n, stdby_ack, fail, retry_cnt, lol_cnt
    );

    modport slave (
        input  extlock, stdby_req,
        output pll_reset, pll_stdby, locked, sys_rst_n, stdby_ack, fail, retry_cnt, lol_cnt
    );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL reset/standby sequencer: retries lock attempts, qualifies extlock, issues locked and sys_rst_n.
// Outputs are registered from the next state; extlock reaches the FSM after a 2-flop synchronizer.
module pll_lock_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 64,
    parameter int MAX_RETRIES  = 3
) (
    input  logic          refclk,
    input  logic          reset_n,
    pll_lock_seq_if.slave bus
);
    localparam int RW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int SW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;

    localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        S_RESET, S_WAIT_LOCK, S_RUN, S_DRAIN, S_STDBY, S_FAIL
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          sync1;
    logic          extlock_s;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] stb_cnt;
    logic          rst_done;
    logic          qualified;
    logic          timed_out;
    logic          retry_ok;

    logic pll_reset_d, pll_stdby_d, locked_d, sys_rst_n_d, stdby_ack_d, fail_d;

    assign rst_done  = (rst_cnt == R_LAST);
    // Qualification fires on the cycle that would complete LOCK_STABLE consecutive highs.
    assign qualified = extlock_s && (stb_cnt == S_LAST);
    assign timed_out = (tmo_cnt == T_LAST);
    assign retry_ok  = (int'(bus.retry_cnt) < MAX_RETRIES);

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            extlock_s <= 1'b0;
        end else begin
            sync1     <= bus.extlock;
            extlock_s <= sync1;
        end
    end

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:     if (rst_done) next_state = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (qualified) begin
                    next_state = S_RUN;
                end else if (timed_out) begin
                    next_state = retry_ok ? S_RESET : S_FAIL;
                end
            end
            S_RUN: begin
                if (!extlock_s) begin
                    next_state = S_RESET;
                end else if (bus.stdby_req) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN:     next_state = S_STDBY;
            S_STDBY:     if (!bus.stdby_req) next_state = S_RESET;
            S_FAIL:      next_state = S_FAIL;
            default:     next_state = S_RESET;
        endcase
    end

    always_comb begin
        pll_reset_d = 1'b0;
        pll_stdby_d = 1'b0;
        locked_d    = 1'b0;
        sys_rst_n_d = 1'b0;
        stdby_ack_d = 1'b0;
        fail_d      = 1'b0;
        case (next_state)
            S_RESET: pll_reset_d = 1'b1;
            S_RUN: begin
                locked_d    = 1'b1;
                sys_rst_n_d = 1'b1;
            end
            S_STDBY: begin
                pll_stdby_d = 1'b1;
                stdby_ack_d = 1'b1;
            end
            S_FAIL: begin
                fail_d      = 1'b1;
                pll_reset_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Per-state counters restart whenever the state is (re)entered.
    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            rst_cnt <= '0;
            tmo_cnt <= '0;
            stb_cnt <= '0;
        end else begin
            rst_cnt <= (state == S_RESET && next_state == S_RESET) ? rst_cnt + RW'(1) : '0;
            tmo_cnt <= (state == S_WAIT_LOCK && next_state == S_WAIT_LOCK) ? tmo_cnt + TW'(1) : '0;
            if (state == S_WAIT_LOCK && next_state == S_WAIT_LOCK && extlock_s) begin
                stb_cnt <= stb_cnt + SW'(1);
            end else begin
                stb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            bus.retry_cnt <= 2'd0;
            bus.lol_cnt   <= 8'd0;
        end else begin
            if (state == S_WAIT_LOCK && qualified) begin
                bus.retry_cnt <= 2'd0;
            end else if (state == S_WAIT_LOCK && timed_out && retry_ok) begin
                bus.retry_cnt <= bus.retry_cnt + 2'd1;
            end else if (state == S_STDBY && next_state == S_RESET) begin
                bus.retry_cnt <= 2'd0;
            end
            if (state == S_RUN && !extlock_s && bus.lol_cnt != 8'hFF) begin
                bus.lol_cnt <= bus.lol_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            bus.pll_reset <= 1'b1;
            bus.pll_stdby <= 1'b0;
            bus.locked    <= 1'b0;
            bus.sys_rst_n <= 1'b0;
            bus.stdby_ack <= 1'b0;
            bus.fail      <= 1'b0;
        end else begin
            bus.pll_reset <= pll_reset_d;
            bus.pll_stdby <= pll_stdby_d;
            bus.locked    <= locked_d;
            bus.sys_rst_n <= sys_rst_n_d;
            bus.stdby_ack <= stdby_ack_d;
            bus.fail      <= fail_d;
        end
    end
endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Sequencer for the on-chip PLL clock divider. It drives the PLL `reset` and `stdby` pins and qualifies the asynchronous `extlock` output. It retries failed lock attempts and recovers from loss of lock. It gives downstream logic a clean `locked` flag and a synchronous system reset. It runs on the PLL reference clock and sits between board reset and the PLL instance.

## Interface
- `RST_CYCLES`, 16: cycles `pll_reset` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- `LOCK_STABLE`, 64: consecutive cycles synchronized `extlock` must be high to qualify lock.
- `MAX_RETRIES`, 3: failed attempts retried before entering FAIL.

- `refclk`  in  1  reference clock (PLL input clock, 50 MHz).
- `reset_n`  in  1  synchronous, active-low reset.
- `extlock`  in  1  PLL lock indicator, asynchronous to `refclk`.
- `stdby_req`  in  1  level request to put the PLL into standby.
- `pll_reset`  out  1  to the PLL `reset` pin, active high.
- `pll_stdby`  out  1  to the PLL `stdby` pin.
- `locked`  out  1  qualified lock; high only in RUN.
- `sys_rst_n`  out  1  downstream synchronous reset, active low.
- `stdby_ack`  out  1  high while in STDBY.
- `fail`  out  1  high in FAIL (sticky until `reset_n`).
- `retry_cnt`  out  2  failed attempts in the current sequence.
- `lol_cnt`  out  8  lock-loss events in RUN; saturates at 255.

## Operation
- `extlock` passes through a 2-flop synchronizer to give `extlock_s`. All outputs are registered.
- Reset (`reset_n` = 0 at an edge) sets the following:
  - state = RESET, counters = 0.
  - `pll_reset` = 1, `pll_stdby` = 0, `locked` = 0, `sys_rst_n` = 0.
  - `stdby_ack` = 0, `fail` = 0, `retry_cnt` = 0, `lol_cnt` = 0.
- **RESET:** `pll_reset` = 1. It stays here for `RST_CYCLES` cycles after `reset_n` is sampled high, or after entry, then goes to WAIT_LOCK.
- **WAIT_LOCK:** `pll_reset` = 0.
  - The timeout counter increments every cycle.
  - The stable counter increments while `extlock_s` = 1 and clears to 0 when `extlock_s` = 0.
  - When the stable counter reaches `LOCK_STABLE`, go to RUN and clear `retry_cnt`.
  - Otherwise, when the timeout counter reaches `LOCK_TIMEOUT`:
    - if `retry_cnt` < `MAX_RETRIES`, increment `retry_cnt` and go to RESET;
    - else go to FAIL.
  - If qualification and timeout happen in the same cycle, qualification wins.
- **RUN:** `locked` = 1, `sys_rst_n` = 1.
  - `extlock_s` = 0 for any single cycle is a lock loss: increment `lol_cnt` (saturating) and go to RESET.
  - Otherwise, `stdby_req` = 1 goes to DRAIN.
  - If lock loss and `stdby_req` occur in the same cycle, lock loss wins.
- **DRAIN:** lasts 1 cycle. `locked` = 0, `sys_rst_n` = 0, `pll_stdby` = 0. Then go to STDBY.
- **STDBY:** `pll_stdby` = 1, `stdby_ack` = 1, `sys_rst_n` = 0. `extlock_s` is ignored. When `stdby_req` = 0, go to RESET with `retry_cnt` = 0.
- **FAIL:** `fail` = 1, `pll_reset` = 1, `sys_rst_n` = 0. This state is terminal; only `reset_n` leaves it.
- `stdby_req` is ignored in every state other than RUN and STDBY.
- Counters are sized by `$clog2` of their parameter. Counters do not wrap; they are compared for equality and cleared on each state entry.

## Timing
- The `extlock` rise reaches `extlock_s` 2 cycles later.
- Lock latency: `locked` rises `LOCK_STABLE` + 2 cycles after `extlock` is stable high, provided the state is WAIT_LOCK.
- `locked` and `sys_rst_n` rise on the same edge and fall on the same edge.
- Lock loss: `locked` falls 3 cycles after `extlock` falls (2 sync + 1 register). `pll_reset` rises on that same edge.
- Entering standby: `sys_rst_n` falls 1 cycle before `pll_stdby` rises. `stdby_ack` rises with `pll_stdby`.
- Leaving standby: `pll_stdby` falls and `pll_reset` rises on the same edge after `stdby_req` is sampled low.
- Reset mid-operation (any state): outputs return to their reset values on the next edge.

## Test plan
Bench parameters: `RST_CYCLES` = 4, `LOCK_TIMEOUT` = 100, `LOCK_STABLE` = 8, `MAX_RETRIES` = 2.

1. Release `reset_n`, then drive `extlock` high 10 cycles into WAIT_LOCK → `pll_reset` is high for exactly 4 cycles after release; `locked` = `sys_rst_n` = 1 exactly 10 cycles after the `extlock` rise; `retry_cnt` = 0.
2. Hold `extlock` low throughout → 3 attempts of 4 + 100 cycles each; `retry_cnt` goes 1, 2; then `fail` = 1 and `pll_reset` = 1 indefinitely; pulsing `reset_n` clears `fail`.
3. Toggle `extlock` high 7 cycles / low 1 cycle repeatedly, then hold high → no qualification until 8 consecutive synchronized highs; no premature `locked`.
4. In RUN, drop `extlock` for 1 cycle → `locked` falls 3 cycles later; `lol_cnt` = 1; `pll_reset` pulses for 4 cycles; lock is re-qualified.
5. In RUN, raise `stdby_req` → `sys_rst_n` = 0, then next cycle `pll_stdby` = `stdby_ack` = 1; dropping `extlock` has no effect; lower `stdby_req` → RESET, then relock.
6. In the same cycle of RUN, drop `extlock_s` and raise `stdby_req` → lock-loss path taken, `lol_cnt` increments, `pll_stdby` stays 0. Separately, assert `reset_n` = 0 during WAIT_LOCK → all outputs return to their reset values next edge.
